// File: rtl/nasti_stream_mover_sched_if.sv
// Bundle between the requesters, the round-robin scheduler and the shared
// NASTI-to-stream mover request port.
interface nasti_stream_mover_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ*ADDR_WIDTH-1:0] req_src;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_len;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic [ADDR_WIDTH-1:0]         m_src;
    logic [ADDR_WIDTH-1:0]         m_len;
    logic                          m_valid;
    logic                          m_ready;
    logic [IDW-1:0]                cur_id;
    logic                          busy;

    // Requesters and the mover sit on the master side.
    modport master (
        output req_src, req_len, req_valid, m_ready,
        input  req_ready, req_done, req_err, m_src, m_len, m_valid, cur_id, busy
    );

    // The scheduler sits on the slave side.
    modport slave (
        input  req_src, req_len, req_valid, m_ready,
        output req_ready, req_done, req_err, m_src, m_len, m_valid, cur_id, busy
    );
endinterface

// File: rtl/nasti_stream_mover_sched.sv
// Round-robin scheduler sharing one NASTI-to-stream mover between NUM_REQ
// requesters, splitting each descriptor into chunks of at most CHUNK_BYTES.
module nasti_stream_mover_sched #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_BYTES = 64
) (
    input logic                       aclk,
    input logic                       aresetn,
    nasti_stream_mover_sched_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH/8 - 1);
    localparam logic [ADDR_WIDTH-1:0] CHUNK      = ADDR_WIDTH'(CHUNK_BYTES);
    localparam logic [IDW-1:0]        LAST_ID    = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT_DONE} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q [NUM_REQ];
    logic [ADDR_WIDTH-1:0] rem_q  [NUM_REQ];
    logic [NUM_REQ-1:0]    occ_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    err_q;
    logic [IDW-1:0]        rr_q;
    logic [IDW-1:0]        cur_id_q;
    logic [ADDR_WIDTH-1:0] m_src_q;
    logic [ADDR_WIDTH-1:0] m_len_q;
    logic                  m_valid_q;

    logic [ADDR_WIDTH-1:0] src_w [NUM_REQ];
    logic [ADDR_WIDTH-1:0] len_w [NUM_REQ];
    logic                  sel_vld;
    logic [IDW-1:0]        sel_id;
    logic [ADDR_WIDTH-1:0] sel_rem;
    logic [ADDR_WIDTH-1:0] sel_len;
    int                    idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            src_w[i] = bus.req_src[i*ADDR_WIDTH +: ADDR_WIDTH];
            len_w[i] = bus.req_len[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Walk backwards from the farthest candidate so the slot closest to the
    // round-robin pointer (wrapping) is the one left selected.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (occ_q[idx]) begin
                sel_vld = 1'b1;
                sel_id  = IDW'(idx);
            end
        end
        sel_rem = rem_q[sel_id];
        sel_len = (sel_rem < CHUNK) ? sel_rem : CHUNK;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            occ_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rr_q      <= '0;
            cur_id_q  <= '0;
            m_src_q   <= '0;
            m_len_q   <= '0;
            m_valid_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
            end
        end else begin
            done_q <= '0;
            err_q  <= '0;

            // A slot only accepts while empty, and the FSM only touches
            // occupied slots, so acceptance and completion never collide.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && !occ_q[i]) begin
                    if (|((src_w[i] | len_w[i]) & ALIGN_MASK)) begin
                        err_q[i] <= 1'b1;
                    end else if (len_w[i] == '0) begin
                        done_q[i] <= 1'b1;
                    end else begin
                        addr_q[i] <= src_w[i];
                        rem_q[i]  <= len_w[i];
                        occ_q[i]  <= 1'b1;
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        m_src_q   <= addr_q[sel_id];
                        m_len_q   <= sel_len;
                        m_valid_q <= 1'b1;
                        cur_id_q  <= sel_id;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.m_ready) begin
                        m_valid_q        <= 1'b0;
                        addr_q[cur_id_q] <= addr_q[cur_id_q] + m_len_q;
                        rem_q[cur_id_q]  <= rem_q[cur_id_q] - m_len_q;
                        rr_q             <= (cur_id_q == LAST_ID) ? '0 : cur_id_q + 1'b1;
                        state_q          <= SETTLE;
                    end
                end
                // The mover drops r_ready only a cycle after accepting, so
                // its ready is not trusted here.
                SETTLE: state_q <= WAIT_DONE;
                WAIT_DONE: begin
                    if (bus.m_ready) begin
                        if (rem_q[cur_id_q] == '0) begin
                            done_q[cur_id_q] <= 1'b1;
                            occ_q[cur_id_q]  <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ~occ_q;
    assign bus.req_done  = done_q;
    assign bus.req_err   = err_q;
    assign bus.m_src     = m_src_q;
    assign bus.m_len     = m_len_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.cur_id    = cur_id_q;
    assign bus.busy      = (|occ_q) || (state_q != IDLE);
endmodule

// File: tb/tb_nasti_stream_mover_sched.sv
// Self-checking bench for nasti_stream_mover_sched: a behavioural mover plus
// scoreboards for mover requests, done pulses and error pulses.
module tb_nasti_stream_mover_sched;
    localparam int NUM_REQ = 4;
    localparam int AW      = 64;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] src;
        logic [63:0] len;
    } chunk_t;

    typedef struct {
        int          slot;
        logic [63:0] src;
        logic [63:0] len;
        int          busyCycles;
        logic        expErr;
        logic        expImmDone;
        int          expChunks;
    } vec_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    nasti_stream_mover_sched_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW)) bus ();

    nasti_stream_mover_sched #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(64), .CHUNK_BYTES(64)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    always #5 aclk = ~aclk;

    int     compared    = 0;
    int     mismatched  = 0;
    chunk_t expQ[$];
    int     doneQ[$];
    int     errQ[$];
    int     hsCount     = 0;
    int     moverBusy   = 2;
    logic   holdReady   = 1'b0;
    int     busyCnt     = 0;
    logic   pendingDrop = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event seen, none expected", name);
    endtask

    // Mover model: ready when idle, busy for moverBusy cycles after each accept.
    always @(negedge aclk) begin
        chunk_t c;
        if (!aresetn) begin
            pendingDrop = 1'b0;
            busyCnt     = 0;
        end else if (pendingDrop) begin
            pendingDrop = 1'b0;
            busyCnt     = moverBusy;
        end else if (busyCnt > 0) begin
            busyCnt--;
        end
        bus.m_ready = (busyCnt == 0) && !holdReady;
        if (aresetn && bus.m_valid && bus.m_ready) begin
            hsCount++;
            pendingDrop = 1'b1;
            if (expQ.size() == 0) begin
                failNow("unexpected_request");
            end else begin
                c = expQ.pop_front();
                checkOutput("m_src", bus.m_src, c.src);
                checkOutput("m_len", bus.m_len, c.len);
                checkOutput("cur_id", 64'(bus.cur_id), 64'(c.id));
            end
        end
    end

    // Completion and error pulse scoreboards.
    always @(negedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_done[i]) begin
                    if (doneQ.size() == 0) failNow("unexpected_done");
                    else checkOutput("done_id", 64'(i), 64'(doneQ.pop_front()));
                end
                if (bus.req_err[i]) begin
                    if (errQ.size() == 0) failNow("unexpected_err");
                    else checkOutput("err_id", 64'(i), 64'(errQ.pop_front()));
                end
            end
        end
    end

    task automatic pushChunks(input int slot, input logic [63:0] src, input logic [63:0] len);
        logic [63:0] a = src;
        logic [63:0] r = len;
        logic [63:0] l;
        while (r != 0) begin
            l = (r > 64'h40) ? 64'h40 : r;
            expQ.push_back('{id: 2'(slot), src: a, len: l});
            a = a + l;
            r = r - l;
        end
        doneQ.push_back(slot);
    endtask

    task automatic waitIdle(input string tag);
        for (int n = 0; n < 2000; n++) begin
            @(posedge aclk); #3;
            if (expQ.size() == 0 && doneQ.size() == 0 && errQ.size() == 0 && !bus.busy) break;
        end
        checkOutput({tag, "_pending"}, 64'(expQ.size() + doneQ.size() + errQ.size()), 64'd0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic waitHandshake(input int hs0, input string tag);
        int n = 0;
        while (hsCount == hs0 && n < 500) begin
            @(posedge aclk); #3;
            n++;
        end
        checkOutput({tag, "_hs_timeout"}, 64'(hsCount == hs0), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'hF);
        checkOutput({tag, "_req_done"}, 64'(bus.req_done), 64'h0);
        checkOutput({tag, "_req_err"}, 64'(bus.req_err), 64'h0);
        checkOutput({tag, "_m_valid"}, 64'(bus.m_valid), 64'h0);
        checkOutput({tag, "_m_src"}, bus.m_src, 64'h0);
        checkOutput({tag, "_m_len"}, bus.m_len, 64'h0);
        checkOutput({tag, "_cur_id"}, 64'(bus.cur_id), 64'h0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int hs0;
        moverBusy = v.busyCycles;
        if (v.expErr) errQ.push_back(v.slot);
        else pushChunks(v.slot, v.src, v.len);
        hs0 = hsCount;
        @(posedge aclk); #2;
        checkOutput("ready_before", 64'(bus.req_ready[v.slot]), 64'd1);
        bus.req_src[v.slot*AW +: AW] = v.src;
        bus.req_len[v.slot*AW +: AW] = v.len;
        bus.req_valid[v.slot]        = 1'b1;
        @(posedge aclk); #1;
        bus.req_valid[v.slot] = 1'b0;
        #2;
        checkOutput("err_pulse", 64'(bus.req_err[v.slot]), 64'(v.expErr));
        checkOutput("done_pulse", 64'(bus.req_done[v.slot]), 64'(v.expImmDone));
        checkOutput("ready_after", 64'(bus.req_ready[v.slot]), 64'(v.expChunks == 0));
        waitIdle("vec");
        checkOutput("chunks", 64'(hsCount - hs0), 64'(v.expChunks));
        checkOutput("ready_all", 64'(bus.req_ready), 64'hF);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   hs0;
        vecs[0] = '{slot: 0, src: 64'h1000, len: 64'h100, busyCycles: 3,  expErr: 0, expImmDone: 0, expChunks: 4};
        vecs[1] = '{slot: 1, src: 64'h2000, len: 64'h48,  busyCycles: 2,  expErr: 0, expImmDone: 0, expChunks: 2};
        vecs[2] = '{slot: 3, src: 64'h3000, len: 64'h0,   busyCycles: 2,  expErr: 0, expImmDone: 1, expChunks: 0};
        vecs[3] = '{slot: 2, src: 64'h1004, len: 64'h40,  busyCycles: 2,  expErr: 1, expImmDone: 0, expChunks: 0};
        vecs[4] = '{slot: 1, src: 64'h1000, len: 64'h44,  busyCycles: 2,  expErr: 1, expImmDone: 0, expChunks: 0};
        vecs[5] = '{slot: 3, src: 64'hFFC0, len: 64'h40,  busyCycles: 20, expErr: 0, expImmDone: 0, expChunks: 1};
        vecs[6] = '{slot: 2, src: 64'h5000, len: 64'h38,  busyCycles: 1,  expErr: 0, expImmDone: 0, expChunks: 1};

        bus.req_src   = '0;
        bus.req_len   = '0;
        bus.req_valid = '0;
        aresetn       = 1'b0;
        repeat (3) @(posedge aclk);
        #3;
        checkResetState("reset");
        aresetn = 1'b1;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Backpressure: request held while the mover refuses, then a long busy mover.
        @(posedge aclk); #2;
        holdReady = 1'b1;
        moverBusy = 20;
        pushChunks(0, 64'h4000, 64'h80);
        bus.req_src[0 +: AW] = 64'h4000;
        bus.req_len[0 +: AW] = 64'h80;
        bus.req_valid[0]     = 1'b1;
        @(posedge aclk); #1;
        bus.req_valid[0] = 1'b0;
        for (int n = 0; n < 20 && !bus.m_valid; n++) begin
            @(posedge aclk); #3;
        end
        for (int n = 0; n < 10; n++) begin
            checkOutput("bp_m_valid", 64'(bus.m_valid), 64'd1);
            checkOutput("bp_m_src", bus.m_src, 64'h4000);
            checkOutput("bp_m_len", bus.m_len, 64'h40);
            @(posedge aclk); #3;
        end
        hs0 = hsCount;
        holdReady = 1'b0;
        waitHandshake(hs0, "bp");
        for (int n = 0; n < 15; n++) begin
            checkOutput("bp_no_issue", 64'(bus.m_valid), 64'd0);
            @(posedge aclk); #3;
        end
        waitIdle("bp");
        checkOutput("bp_chunks", 64'(hsCount - hs0), 64'd2);

        // Reset while the mover is working on the first chunk of slot 1.
        moverBusy = 10;
        pushChunks(1, 64'h6000, 64'h100);
        hs0 = hsCount;
        @(posedge aclk); #2;
        bus.req_src[AW +: AW] = 64'h6000;
        bus.req_len[AW +: AW] = 64'h100;
        bus.req_valid[1]      = 1'b1;
        @(posedge aclk); #1;
        bus.req_valid[1] = 1'b0;
        waitHandshake(hs0, "rst");
        repeat (4) @(posedge aclk);
        #3;
        aresetn = 1'b0;
        expQ.delete();
        doneQ.delete();
        errQ.delete();
        #1;
        checkResetState("midreset");
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;

        // Interleave from a fresh round-robin pointer: slots 0 and 2 posted together.
        moverBusy = 3;
        expQ.push_back('{id: 2'd0, src: 64'h0,    len: 64'h40});
        expQ.push_back('{id: 2'd2, src: 64'h8000, len: 64'h40});
        expQ.push_back('{id: 2'd0, src: 64'h40,   len: 64'h40});
        doneQ.push_back(2);
        doneQ.push_back(0);
        hs0 = hsCount;
        @(posedge aclk); #2;
        bus.req_src[0 +: AW]    = 64'h0;
        bus.req_len[0 +: AW]    = 64'h80;
        bus.req_src[2*AW +: AW] = 64'h8000;
        bus.req_len[2*AW +: AW] = 64'h40;
        bus.req_valid           = 4'b0101;
        @(posedge aclk); #1;
        bus.req_valid = '0;
        waitIdle("ilv");
        checkOutput("ilv_chunks", 64'(hsCount - hs0), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
